// File: rtl/storage_exc_ctrl.sv
// Exception-entry sequencer for DSI/ISI storage exceptions and rfi.
// Flushes the pipeline, saves context, loads the exception MSR, redirects fetch, then acks the detector.
module storage_exc_ctrl #(
   parameter logic [31:0] VEC_DSI      = 32'h0000_0300,
   parameter logic [31:0] VEC_ISI      = 32'h0000_0400,
   parameter logic [31:0] VEC_HI       = 32'hFFF0_0000,
   parameter logic [31:0] MSR_CLR_MASK = 32'h0000_E77B
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dsi,
   input  logic        isi,
   input  logic        dsi_is_store,
   input  logic [31:0] dsi_ea,
   input  logic [31:0] pc_mem,
   input  logic [31:0] pc_fetch,
   input  logic [31:0] msr_in,
   input  logic [31:0] srr0_in,
   input  logic [31:0] srr1_in,
   input  logic        rfi_req,
   input  logic        drain_done,
   output logic        ack_dsi,
   output logic        ack_isi,
   output logic        rfi_ack,
   output logic        flush,
   output logic        srr0_we,
   output logic [31:0] srr0_wd,
   output logic        srr1_we,
   output logic [31:0] srr1_wd,
   output logic        dar_we,
   output logic [31:0] dar_wd,
   output logic        dsisr_we,
   output logic [31:0] dsisr_wd,
   output logic        msr_we,
   output logic [31:0] msr_wd,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FLUSH,
      S_SAVE,
      S_VECTOR,
      S_ACK,
      S_RFI
   } state_t;

   state_t      state, state_nxt;
   logic        cause_dsi;
   logic        cap_store;
   logic [31:0] cap_msr;
   logic [31:0] cap_pc;
   logic [31:0] cap_ea;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cause_dsi <= 1'b0;
         cap_store <= 1'b0;
         cap_msr   <= '0;
         cap_pc    <= '0;
         cap_ea    <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && (dsi || isi)) begin
            cause_dsi <= dsi;
            cap_store <= dsi_is_store;
            cap_msr   <= msr_in;
            cap_pc    <= dsi ? pc_mem : pc_fetch;
            cap_ea    <= dsi_ea;
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      ack_dsi     = 1'b0;
      ack_isi     = 1'b0;
      rfi_ack     = 1'b0;
      flush       = 1'b0;
      srr0_we     = 1'b0;
      srr0_wd     = '0;
      srr1_we     = 1'b0;
      srr1_wd     = '0;
      dar_we      = 1'b0;
      dar_wd      = '0;
      dsisr_we    = 1'b0;
      dsisr_wd    = '0;
      msr_we      = 1'b0;
      msr_wd      = '0;
      redirect    = 1'b0;
      redirect_pc = '0;
      busy        = (state != S_IDLE);

      case (state)
         S_IDLE: begin
            if (dsi || isi)
               state_nxt = S_FLUSH;
            else if (rfi_req)
               state_nxt = S_RFI;
         end
         S_FLUSH: begin
            flush = 1'b1;
            if (drain_done)
               state_nxt = S_SAVE;
         end
         S_SAVE: begin
            srr0_we = 1'b1;
            srr0_wd = cap_pc;
            srr1_we = 1'b1;
            srr1_wd = cap_msr;
            if (cause_dsi) begin
               dar_we   = 1'b1;
               dar_wd   = cap_ea;
               dsisr_we = 1'b1;
               dsisr_wd = 32'h0800_0000 | (cap_store ? 32'h0200_0000 : 32'h0000_0000);
            end
            state_nxt = S_VECTOR;
         end
         S_VECTOR: begin
            msr_we      = 1'b1;
            msr_wd      = cap_msr & ~MSR_CLR_MASK;
            redirect    = 1'b1;
            // MSR[IP] is bit 25 in big-endian numbering, i.e. bit 6 here
            redirect_pc = (cap_msr[6] ? VEC_HI : 32'h0000_0000) | (cause_dsi ? VEC_DSI : VEC_ISI);
            state_nxt   = S_VECTOR == state ? S_ACK : S_IDLE;
         end
         S_ACK: begin
            ack_dsi = cause_dsi;
            // a fetch fault behind a DSI is younger and already flushed, so drop it
            ack_isi = !cause_dsi || isi;
            state_nxt = S_IDLE;
         end
         S_RFI: begin
            msr_we      = 1'b1;
            msr_wd      = srr1_in;
            redirect    = 1'b1;
            redirect_pc = srr0_in;
            rfi_ack     = 1'b1;
            state_nxt   = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_storage_exc_ctrl.sv
// Self-checking bench for storage_exc_ctrl: directed cases plus randomized exception/rfi sequences
// checked cycle by cycle against per-phase expectations derived from the exception rules.
module tb_storage_exc_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        dsi, isi, dsi_is_store;
   logic [31:0] dsi_ea, pc_mem, pc_fetch, msr_in, srr0_in, srr1_in;
   logic        rfi_req, drain_done;
   logic        ack_dsi, ack_isi, rfi_ack, flush;
   logic        srr0_we, srr1_we, dar_we, dsisr_we, msr_we, redirect, busy;
   logic [31:0] srr0_wd, srr1_wd, dar_wd, dsisr_wd, msr_wd, redirect_pc;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic        ack_dsi, ack_isi, rfi_ack, flush;
      logic        srr0_we;  logic [31:0] srr0_wd;
      logic        srr1_we;  logic [31:0] srr1_wd;
      logic        dar_we;   logic [31:0] dar_wd;
      logic        dsisr_we; logic [31:0] dsisr_wd;
      logic        msr_we;   logic [31:0] msr_wd;
      logic        redirect; logic [31:0] redirect_pc;
      logic        busy;
   } outs_t;

   storage_exc_ctrl #(
      .VEC_DSI(32'h0000_0300),
      .VEC_ISI(32'h0000_0400),
      .VEC_HI(32'hFFF0_0000),
      .MSR_CLR_MASK(32'h0000_E77B)
   ) dut (
      .clk(clk), .rst(rst), .dsi(dsi), .isi(isi), .dsi_is_store(dsi_is_store),
      .dsi_ea(dsi_ea), .pc_mem(pc_mem), .pc_fetch(pc_fetch), .msr_in(msr_in),
      .srr0_in(srr0_in), .srr1_in(srr1_in), .rfi_req(rfi_req), .drain_done(drain_done),
      .ack_dsi(ack_dsi), .ack_isi(ack_isi), .rfi_ack(rfi_ack), .flush(flush),
      .srr0_we(srr0_we), .srr0_wd(srr0_wd), .srr1_we(srr1_we), .srr1_wd(srr1_wd),
      .dar_we(dar_we), .dar_wd(dar_wd), .dsisr_we(dsisr_we), .dsisr_wd(dsisr_wd),
      .msr_we(msr_we), .msr_wd(msr_wd), .redirect(redirect), .redirect_pc(redirect_pc),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic expect_outs(input string ph, input outs_t e);
      chk({ph, ".ack_dsi"},     32'(ack_dsi),     32'(e.ack_dsi));
      chk({ph, ".ack_isi"},     32'(ack_isi),     32'(e.ack_isi));
      chk({ph, ".rfi_ack"},     32'(rfi_ack),     32'(e.rfi_ack));
      chk({ph, ".flush"},       32'(flush),       32'(e.flush));
      chk({ph, ".srr0_we"},     32'(srr0_we),     32'(e.srr0_we));
      chk({ph, ".srr0_wd"},     srr0_wd,          e.srr0_wd);
      chk({ph, ".srr1_we"},     32'(srr1_we),     32'(e.srr1_we));
      chk({ph, ".srr1_wd"},     srr1_wd,          e.srr1_wd);
      chk({ph, ".dar_we"},      32'(dar_we),      32'(e.dar_we));
      chk({ph, ".dar_wd"},      dar_wd,           e.dar_wd);
      chk({ph, ".dsisr_we"},    32'(dsisr_we),    32'(e.dsisr_we));
      chk({ph, ".dsisr_wd"},    dsisr_wd,         e.dsisr_wd);
      chk({ph, ".msr_we"},      32'(msr_we),      32'(e.msr_we));
      chk({ph, ".msr_wd"},      msr_wd,           e.msr_wd);
      chk({ph, ".redirect"},    32'(redirect),    32'(e.redirect));
      chk({ph, ".redirect_pc"}, redirect_pc,      e.redirect_pc);
      chk({ph, ".busy"},        32'(busy),        32'(e.busy));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full exception entry from IDLE; optionally an rfi held alongside, taken afterwards.
   task automatic run_exc(input string nm, input logic d, input logic i, input logic st,
                          input logic [31:0] msr, input logic [31:0] pcm, input logic [31:0] pcf,
                          input logic [31:0] ea, input int unsigned dly, input logic with_rfi,
                          input logic [31:0] s0, input logic [31:0] s1);
      outs_t e;
      dsi = d; isi = i; dsi_is_store = st; msr_in = msr; pc_mem = pcm; pc_fetch = pcf;
      dsi_ea = ea; rfi_req = with_rfi; srr0_in = s0; srr1_in = s1; drain_done = 1'b0;
      e = '0;
      expect_outs({nm, ".idle0"}, e);
      for (int unsigned k = 0; k <= dly; k++) begin
         step();
         // inputs that the cause was captured from change freely once in FLUSH
         msr_in = $urandom; pc_mem = $urandom; pc_fetch = $urandom; dsi_ea = $urandom;
         dsi_is_store = 1'($urandom);
         e = '0; e.flush = 1'b1; e.busy = 1'b1;
         expect_outs($sformatf("%s.flush%0d", nm, k), e);
         drain_done = (k == dly);
      end
      step();
      drain_done = 1'b0;
      e = '0; e.busy = 1'b1;
      e.srr0_we = 1'b1; e.srr0_wd = d ? pcm : pcf;
      e.srr1_we = 1'b1; e.srr1_wd = msr;
      if (d) begin
         e.dar_we = 1'b1; e.dar_wd = ea;
         e.dsisr_we = 1'b1; e.dsisr_wd = 32'h0800_0000 + (st ? 32'h0200_0000 : 32'h0);
      end
      expect_outs({nm, ".save"}, e);
      step();
      e = '0; e.busy = 1'b1;
      e.msr_we = 1'b1; e.msr_wd = msr & 32'hFFFF_1884;
      e.redirect = 1'b1;
      e.redirect_pc = (((msr & 32'h40) != 0) ? 32'hFFF0_0000 : 32'h0) + (d ? 32'h300 : 32'h400);
      expect_outs({nm, ".vector"}, e);
      step();
      e = '0; e.busy = 1'b1; e.ack_dsi = d; e.ack_isi = i;
      expect_outs({nm, ".ack"}, e);
      step();
      dsi = 1'b0; isi = 1'b0;
      e = '0;
      expect_outs({nm, ".idle1"}, e);
      step();
      if (with_rfi) begin
         e = '0; e.busy = 1'b1; e.rfi_ack = 1'b1;
         e.msr_we = 1'b1; e.msr_wd = s1; e.redirect = 1'b1; e.redirect_pc = s0;
         expect_outs({nm, ".rfi"}, e);
         rfi_req = 1'b0;
         step();
      end
      e = '0;
      expect_outs({nm, ".idle2"}, e);
   endtask

   task automatic run_rfi(input string nm, input logic [31:0] s0, input logic [31:0] s1);
      outs_t e;
      rfi_req = 1'b1; srr0_in = s0; srr1_in = s1;
      step();
      e = '0; e.busy = 1'b1; e.rfi_ack = 1'b1;
      e.msr_we = 1'b1; e.msr_wd = s1; e.redirect = 1'b1; e.redirect_pc = s0;
      expect_outs({nm, ".rfi"}, e);
      rfi_req = 1'b0;
      step();
      e = '0;
      expect_outs({nm, ".idle"}, e);
   endtask

   initial begin
      outs_t z;
      z = '0;
      rst = 1'b1; dsi = 1'b0; isi = 1'b0; dsi_is_store = 1'b0; dsi_ea = '0; pc_mem = '0;
      pc_fetch = '0; msr_in = '0; srr0_in = '0; srr1_in = '0; rfi_req = 1'b0; drain_done = 1'b0;
      repeat (3) step();
      expect_outs("reset", z);
      rst = 1'b0;
      step();

      run_exc("dsi_load", 1, 0, 0, 32'h0000_4040, 32'h100, 32'h0, 32'h2000, 0, 0, 0, 0);
      run_exc("isi_slow", 0, 1, 0, 32'h0000_0000, 32'h0, 32'h3000, 32'h0, 4, 0, 0, 0);
      run_exc("both_st", 1, 1, 1, 32'h0000_8000, 32'h240, 32'h880, 32'hDEAD_BEE0, 1, 0, 0, 0);
      run_rfi("rfi", 32'h500, 32'h4000);
      run_exc("dsi_rfi", 1, 0, 0, 32'h0000_0002, 32'h700, 32'h0, 32'h10, 0, 1, 32'h500, 32'h4000);
      run_exc("msr_clr", 0, 1, 0, 32'hFFFF_FFFF, 32'h0, 32'h1234, 32'h0, 2, 0, 0, 0);

      // reset mid-FLUSH aborts; request still high restarts afterwards
      dsi = 1'b1; isi = 1'b0; pc_mem = 32'h900; msr_in = 32'h40; dsi_ea = 32'h44; drain_done = 1'b0;
      step();
      chk("rstflush.flush", 32'(flush), 32'h1);
      rst = 1'b1;
      step();
      expect_outs("rstflush.after", z);
      rst = 1'b0;
      run_exc("rstflush.retry", 1, 0, 0, 32'h40, 32'h900, 32'h0, 32'h44, 0, 0, 0, 0);

      for (int n = 0; n < 25; n++) begin
         logic d, i;
         d = 1'($urandom); i = 1'($urandom);
         if (!d && !i) i = 1'b1;
         run_exc($sformatf("rnd%0d", n), d, i, 1'($urandom), $urandom, $urandom, $urandom,
                 $urandom, $urandom_range(0, 5), 1'($urandom), $urandom, $urandom);
         if ($urandom_range(0, 3) == 0)
            run_rfi($sformatf("rndrfi%0d", n), $urandom, $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
